// File: rtl/lab2_serial_pkg.sv
// rtl/lab2_serial_pkg.sv - shared state encodings and sizing for the serial reconstruct adder
package lab2_serial_pkg;

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_CNT_W = $clog2(DEFAULT_WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Counter must index 0..WIDTH-1; guard against a degenerate zero-width result.
  function automatic int cnt_width(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/lab2_full_adder_cell.sv
// rtl/lab2_full_adder_cell.sv - one-bit full adder / full subtractor cell
module lab2_full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  input  logic sub,
  output logic s,
  output logic cout
);

  logic a_eff;

  // Inverting the minuend turns the carry recurrence into the borrow recurrence;
  // with sub tied low the inversion disappears entirely.
  assign a_eff = a ^ sub;
  assign s     = a ^ b ^ cin;
  assign cout  = (a_eff & b) | (cin & (a_eff ^ b));

endmodule

// File: rtl/lab2_serial_reconstruct_adder.sv
// rtl/lab2_serial_reconstruct_adder.sv - bit-serial x = D + y reconstruction stage; SERIAL_SUB_EN adds a subtract mode
module lab2_serial_reconstruct_adder
  import lab2_serial_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             bit_valid,
  input  logic             d_in,
  input  logic             y_in,
`ifdef SERIAL_SUB_EN
  input  logic             mode,
`endif
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] x_out,
  output logic             carry_out
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [CW-1:0]    count;
  logic             carry_reg;
  logic [WIDTH-1:0] shift_reg;
  logic [WIDTH-1:0] shift_next;
  logic             sub_sel;
  logic             sum_bit;
  logic             carry_next;

`ifdef SERIAL_SUB_EN
  logic mode_reg;
  assign sub_sel = mode_reg;
`else
  assign sub_sel = 1'b0;
`endif

  lab2_full_adder_cell u_cell (
    .a    (d_in),
    .b    (y_in),
    .cin  (carry_reg),
    .sub  (sub_sel),
    .s    (sum_bit),
    .cout (carry_next)
  );

  // LSB arrives first, so sums enter at the top and drift down to bit 0.
  assign shift_next = {sum_bit, shift_reg[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ready     <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      x_out     <= '0;
      carry_out <= 1'b0;
      count     <= '0;
      carry_reg <= 1'b0;
      shift_reg <= '0;
`ifdef SERIAL_SUB_EN
      mode_reg  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            carry_reg <= 1'b0;
            count     <= '0;
            shift_reg <= '0;
`ifdef SERIAL_SUB_EN
            mode_reg  <= mode;
`endif
            state     <= RUN;
            ready     <= 1'b0;
            busy      <= 1'b1;
          end
        end
        RUN: begin
          if (bit_valid) begin
            carry_reg <= carry_next;
            shift_reg <= shift_next;
            count     <= count + CW'(1);
            if (count == LAST) begin
              x_out     <= shift_next;
              carry_out <= carry_next;
              state     <= DONE;
              busy      <= 1'b0;
              done      <= 1'b1;
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          ready <= 1'b1;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          ready <= 1'b1;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lab2_serial_reconstruct_adder.sv
// tb/tb_lab2_serial_reconstruct_adder.sv - randomized self-checking bench; honours SERIAL_SUB_EN
module tb_lab2_serial_reconstruct_adder;

  localparam int W = 8;
`ifdef SERIAL_SUB_EN
  localparam bit SUB = 1'b1;
`else
  localparam bit SUB = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         bit_valid = 1'b0;
  logic         d_in = 1'b0;
  logic         y_in = 1'b0;
  logic         mode = 1'b0;
  logic         ready;
  logic         busy;
  logic         done;
  logic [W-1:0] x_out;
  logic         carry_out;

  int           checks = 0;
  int           failures = 0;
  logic [W-1:0] prev_x = '0;
  logic         prev_c = 1'b0;

  always #5 clk = ~clk;

  lab2_serial_reconstruct_adder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .bit_valid (bit_valid),
    .d_in      (d_in),
    .y_in      (y_in),
`ifdef SERIAL_SUB_EN
    .mode      (mode),
`endif
    .ready     (ready),
    .busy      (busy),
    .done      (done),
    .x_out     (x_out),
    .carry_out (carry_out)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    checks++;
    if ({ready, busy, done} !== 3'b100) begin
      failures++;
      $display("FAIL reset_flags got=%b want=100", {ready, busy, done});
    end
    checks++;
    if ({carry_out, x_out} !== 9'h000) begin
      failures++;
      $display("FAIL reset_outputs got=%h want=000", {carry_out, x_out});
    end
    prev_x = '0;
    prev_c = 1'b0;
  endtask

  // stall: 0 = continuous, 1 = valid on every second cycle (first low), 2 = random
  task automatic run_word(input logic [W-1:0] d, input logic [W-1:0] y, input logic m,
                          input int stall, input bit inject, input int exp_cycles);
    logic [W-1:0] ex;
    logic         ec;
    int           idx;
    int           cyc;
    logic         bv;
    if (m) begin
      ex = d - y;
      ec = (d < y);
    end else begin
      ex = W'((int'(d) + int'(y)) % (1 << W));
      ec = (int'(d) + int'(y)) >= (1 << W);
    end
    start     = 1'b1;
    mode      = m;
    bit_valid = 1'b1;
    d_in      = 1'($urandom);
    y_in      = 1'($urandom);
    tick();
    start = 1'b0;
    checks++;
    if ({ready, busy, done} !== 3'b010) begin
      failures++;
      $display("FAIL run_entry got=%b want=010", {ready, busy, done});
    end
    idx = 0;
    cyc = 0;
    while (idx < W && cyc < 200) begin
      case (stall)
        0:       bv = 1'b1;
        1:       bv = (cyc % 2 == 1);
        default: bv = 1'($urandom);
      endcase
      bit_valid = bv;
      d_in  = bv ? d[idx] : 1'($urandom);
      y_in  = bv ? y[idx] : 1'($urandom);
      start = inject ? 1'($urandom) : 1'b0;
      mode  = 1'($urandom);
      tick();
      cyc++;
      if (bv) idx++;
      if (idx < W) begin
        checks++;
        if (done !== 1'b0 || busy !== 1'b1 || x_out !== prev_x || carry_out !== prev_c) begin
          failures++;
          $display("FAIL run_hold cyc=%0d done=%b busy=%b x=%h c=%b want x=%h c=%b",
                   cyc, done, busy, x_out, carry_out, prev_x, prev_c);
        end
      end
    end
    bit_valid = 1'b0;
    checks++;
    if (idx < W) begin
      failures++;
      $display("FAIL run_timeout bits=%0d want=%0d", idx, W);
    end else if (done !== 1'b1 || x_out !== ex || carry_out !== ec || ready !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL result d=%h y=%h m=%b got done=%b x=%h c=%b want done=1 x=%h c=%b",
               d, y, m, done, x_out, carry_out, ex, ec);
    end
    if (exp_cycles > 0) begin
      checks++;
      if (cyc !== exp_cycles) begin
        failures++;
        $display("FAIL latency got=%0d want=%0d", cyc, exp_cycles);
      end
    end
    prev_x = ex;
    prev_c = ec;
    start = inject;
    tick();
    start = 1'b0;
    checks++;
    if ({ready, busy, done} !== 3'b100 || x_out !== prev_x || carry_out !== prev_c) begin
      failures++;
      $display("FAIL after_done flags=%b x=%h c=%b want flags=100 x=%h c=%b",
               {ready, busy, done}, x_out, carry_out, prev_x, prev_c);
    end
  endtask

  task automatic test_directed_add();
    run_word(8'h35, 8'h0A, 1'b0, 0, 1'b0, W);
    run_word(8'hF0, 8'h20, 1'b0, 0, 1'b0, W);
  endtask

  task automatic test_stall();
    run_word(8'h01, 8'h01, 1'b0, 1, 1'b0, 2 * W);
  endtask

  task automatic test_ignored_controls();
    bit_valid = 1'b1;
    d_in = 1'b1;
    y_in = 1'b1;
    tick();
    tick();
    bit_valid = 1'b0;
    checks++;
    if ({ready, busy, done} !== 3'b100 || x_out !== prev_x) begin
      failures++;
      $display("FAIL idle_bits flags=%b x=%h want flags=100 x=%h", {ready, busy, done}, x_out, prev_x);
    end
    run_word(8'h5C, 8'h27, 1'b0, 2, 1'b1, 0);
  endtask

  task automatic test_reset_abort();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bit_valid = 1'b1;
      d_in = 1'b1;
      y_in = 1'b0;
      tick();
    end
    rst = 1'b1;
    start = 1'b1;
    tick();
    rst = 1'b0;
    start = 1'b0;
    bit_valid = 1'b0;
    checks++;
    if ({ready, busy, done} !== 3'b100 || x_out !== '0 || carry_out !== 1'b0) begin
      failures++;
      $display("FAIL abort flags=%b x=%h c=%b want flags=100 x=00 c=0", {ready, busy, done}, x_out, carry_out);
    end
    prev_x = '0;
    prev_c = 1'b0;
    run_word(8'hAA, 8'h55, 1'b0, 0, 1'b0, W);
  endtask

  task automatic test_sub();
    if (SUB) begin
      run_word(8'h05, 8'h07, 1'b1, 0, 1'b0, W);
      run_word(8'h09, 8'h03, 1'b1, 2, 1'b0, 0);
    end
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 24; n++) begin
      run_word(W'($urandom), W'($urandom), SUB ? 1'($urandom) : 1'b0,
               int'($urandom_range(0, 2)), 1'($urandom), 0);
    end
  endtask

  initial begin
    test_reset();
    test_directed_add();
    test_stall();
    test_ignored_controls();
    test_reset_abort();
    test_sub();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
